// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// The transmitter imports the same package.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage : uart_defs

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so idle-high and idle-low lines can share this block.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB first, with a
// one-cycle done strobe and a framing-error flag taken from the stop sample.
module uart_rx
  import uart_defs::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int BIT_W = $clog2(DATA_BITS);

  logic                 rx_s;
  uart_state_t          state_reg,     state_next;
  logic [4:0]           tick_cnt_reg,  tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg,   bit_cnt_next;
  logic [DATA_BITS-1:0] shreg_reg,     shreg_next;
  logic [DATA_BITS-1:0] rx_data_reg,   rx_data_next;
  logic                 rx_done_reg,   rx_done_next;
  logic                 frame_err_reg, frame_err_next;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      rx_data_reg   <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Start edge is acted on immediately; s_tick only matters once framing begins.
        if (!rx_s) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt_reg == 5'(MID_SAMPLE)) begin
            if (!rx_s) begin
              state_next    = DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt_reg == 5'(OVERSAMPLE - 1)) begin
            shreg_next    = {rx_s, shreg_reg[DATA_BITS-1:1]};
            tick_cnt_next = '0;
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
              state_next = STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_cnt_reg == 5'(STOP_TICKS - 1)) begin
            rx_data_next   = shreg_reg;
            rx_done_next   = 1'b1;
            frame_err_next = ~rx_s;
            state_next     = IDLE;
          end else begin
            tick_cnt_next = tick_cnt_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes,
// compared against a frame-level queue of expected {frame_err, data}.
module tb_uart_rx;
  import uart_defs::*;

  localparam int DB = 8;
  localparam int ST = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;

  uart_rx #(.DATA_BITS(DB), .STOP_TICKS(ST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // s_tick: one clk wide, every 4 clk, changed on the falling edge
  int tick_div = 0;
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    s_tick   = (tick_div == 0);
  end

  // Output monitor
  logic [DB:0] got_q[$];
  int done_cnt   = 0;
  int wide_pulse = 0;
  int stray_err  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      got_q.push_back({frame_err, rx_data});
      done_cnt++;
      $display("rx_done: data=%02h frame_err=%0b", rx_data, frame_err);
    end
    if (rx_done === 1'b1 && prev_done === 1'b1) wide_pulse++;
    if (frame_err === 1'b1 && rx_done !== 1'b1) stray_err++;
    prev_done = rx_done;
  end

  // Reference model: what a correct receiver must report, one entry per frame sent
  logic [DB:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #1;
  endtask

  // Drives one frame bit-aligned to s_tick; stop_len ticks of stop level then idle.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                            input int stop_len, input int gap);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop_bit;
    wait_ticks(stop_len);
    rx = 1'b1;
    if (gap > 0) wait_ticks(gap);
    exp_q.push_back({~stop_bit, d});
  endtask

  task automatic check_frames(input string tag);
    logic [DB:0] e;
    logic [DB:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({tag, "_missing"}, 32'd0, 32'd1);
      end else begin
        g = got_q.pop_front();
        check({tag, "_data"}, 32'(g[DB-1:0]), 32'(e[DB-1:0]));
        check({tag, "_ferr"}, 32'(g[DB]), 32'(e[DB]));
      end
    end
    check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  int exp_frames = 0;
  int snap;

  initial begin
    // Reset and idle line
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_done", 32'(rx_done), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    repeat (400) @(posedge clk);
    #1;
    check("idle_done_cnt", 32'(done_cnt), 32'd0);
    check("idle_data", 32'(rx_data), 32'd0);
    check("idle_ferr", 32'(frame_err), 32'd0);

    // Single good frame, then hold check
    wait_ticks(1);
    send_frame(8'hA5, 1'b1, 16, 20);
    exp_frames++;
    check_frames("frame_a5");
    check("a5_hold", 32'(rx_data), 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 16, 0);
    send_frame(8'hFF, 1'b1, 16, 20);
    exp_frames += 2;
    check_frames("b2b");

    // Bad stop bit; line returns high before the re-entered START reaches mid-bit
    send_frame(8'h3C, 1'b0, 10, 30);
    exp_frames++;
    check_frames("stop_err");

    // Short low glitch must be rejected
    snap = done_cnt;
    rx = 1'b0;
    wait_ticks(2);
    check("glitch_start", 32'(dut.state_reg), 32'(START));
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(12);
    check("glitch_idle", 32'(dut.state_reg), 32'(IDLE));
    check("glitch_no_done", 32'(done_cnt), 32'(snap));
    send_frame(8'h81, 1'b1, 16, 10);
    exp_frames++;
    check_frames("after_glitch");

    // Reset mid-data of 0x55 (start + bits 1,0,1 then half of bit 3)
    snap = done_cnt;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(8);
    rx = 1'b1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_state", 32'(dut.state_reg), 32'(IDLE));
    check("rst_tick", 32'(dut.tick_cnt_reg), 32'd0);
    check("rst_shreg", 32'(dut.shreg_reg), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_done", 32'(rx_done), 32'd0);
    reset_n = 1'b1;
    wait_ticks(200);
    check("rst_no_done", 32'(done_cnt), 32'(snap));
    send_frame(8'h12, 1'b1, 16, 10);
    exp_frames++;
    check_frames("after_reset");

    // Random bytes with random idle gaps (including none)
    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom), 1'b1, 16, int'($urandom_range(0, 20)));
      exp_frames++;
    end
    check_frames("random");

    check("total_done", 32'(done_cnt), 32'(exp_frames));
    check("pulse_width", 32'(wide_pulse), 32'd0);
    check("stray_ferr", 32'(stray_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
